// File: rtl/lap_time_counter_pkg.sv
// Shared stopwatch definitions: digit widths, digit indices, packed time layout.
package lap_time_counter_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned TIME_W     = DIGIT_W * NUM_DIGITS;

  // Digit indices, least significant first
  localparam int unsigned SEC_ONES = 0;
  localparam int unsigned SEC_TENS = 1;
  localparam int unsigned MIN_ONES = 2;
  localparam int unsigned MIN_TENS = 3;

  // Bit positions of each digit inside the packed time word
  localparam int unsigned SEC_ONES_LSB = SEC_ONES * DIGIT_W;
  localparam int unsigned SEC_TENS_LSB = SEC_TENS * DIGIT_W;
  localparam int unsigned MIN_ONES_LSB = MIN_ONES * DIGIT_W;
  localparam int unsigned MIN_TENS_LSB = MIN_TENS * DIGIT_W;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } time_bcd_t;

  // Binary 0..99 to two BCD digits by repeated subtraction
  function automatic logic [7:0] to_bcd8(input int unsigned value);
    int unsigned rem;
    int unsigned tens;
    rem  = value;
    tens = 0;
    for (int i = 0; i < 10; i++) begin
      if (rem >= 10) begin
        rem  = rem - 10;
        tens = tens + 1;
      end
    end
    return {4'(tens), 4'(rem)};
  endfunction

endpackage

// File: rtl/lap_time_counter_digit.sv
// One BCD digit slice: up/down step with carry/borrow, synchronous load.
module bcd_digit
  import lap_time_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_in,
  input  logic               down,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_c
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] value_next;

  // Next digit value and carry/borrow toward the next slice
  always_comb begin
    value_next = value;
    carry_c    = step_in & (down ? (value == '0) : (value == TOP));
    if (load) begin
      value_next = load_val;
    end else if (step_in) begin
      if (down) begin
        value_next = (value == '0) ? TOP : value - DIGIT_W'(1);
      end else begin
        value_next = (value == TOP) ? '0 : value + DIGIT_W'(1);
      end
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/lap_time_counter.sv
// mm:ss BCD stopwatch counter with limit handling and a lap capture register.
module lap_time_counter
  import lap_time_counter_pkg::*;
#(
  parameter int unsigned MAX_MINUTES = 59,
  parameter bit          WRAP        = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              enable,
  input  logic              clear,
  input  logic              down,
  input  logic              load,
  input  logic [TIME_W-1:0] load_value,
  input  logic              lap_req,
  input  logic              lap_ack,
  output logic [TIME_W-1:0] time_bcd,
  output logic [TIME_W-1:0] lap_time,
  output logic              lap_valid,
  output logic              lap_overrun,
  output logic              at_limit,
  output logic              expired
);

  localparam logic [7:0]        MAX_MIN_BCD = to_bcd8(MAX_MINUTES);
  localparam logic [TIME_W-1:0] MAX_TIME    = {MAX_MIN_BCD, 8'h59};

  logic [DIGIT_W-1:0]    digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] step_in;
  time_bcd_t             count;
  time_bcd_t             lv;
  logic                  load_ok;
  logic                  step_en;
  logic                  at_max;
  logic                  at_zero;
  logic                  boundary;
  logic                  wrap_load;
  logic                  digit_load;
  logic [TIME_W-1:0]     digit_load_val;

  assign count    = {digit_q[MIN_TENS], digit_q[MIN_ONES], digit_q[SEC_TENS], digit_q[SEC_ONES]};
  assign time_bcd = count;
  assign lv       = load_value;

  // Preset is accepted only if every digit is in range for its position
  assign load_ok = (lv.sec_ones <= 4'd9) && (lv.sec_tens <= 4'd5) &&
                   (lv.min_ones <= 4'd9) && (lv.min_tens <= 4'd9) &&
                   ({lv.min_tens, lv.min_ones} <= MAX_MIN_BCD);

  // Limit detection, count-step qualification and digit load muxing
  always_comb begin
    at_max     = (count == MAX_TIME);
    at_zero    = (count == '0);
    boundary   = down ? at_zero : at_max;
    at_limit   = boundary;
    step_en    = tick & enable & ~clear & ~load;
    wrap_load  = step_en & WRAP & boundary;
    digit_load = clear | (load & load_ok) | wrap_load;
    if (clear) begin
      digit_load_val = '0;
    end else if (load) begin
      digit_load_val = load_value;
    end else begin
      digit_load_val = down ? MAX_TIME : '0;
    end
  end

  // Four cascaded digit slices; seconds-tens rolls at 6, the rest at 10
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign step_in[i] = step_en & ~boundary;
    end else begin : g_chain
      assign step_in[i] = carry[i-1];
    end
    bcd_digit #(
      .MODULUS((i == SEC_TENS) ? 6 : 10)
    ) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_in  (step_in[i]),
      .down     (down),
      .load     (digit_load),
      .load_val (digit_load_val[i*DIGIT_W +: DIGIT_W]),
      .value    (digit_q[i]),
      .carry_c  (carry[i])
    );
  end

  // Expiry pulse: a real down-step from 00:01 to 00:00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired <= 1'b0;
    end else begin
      expired <= step_en & down & (count == TIME_W'(1));
    end
  end

  // Lap capture handshake and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_time    <= '0;
      lap_valid   <= 1'b0;
      lap_overrun <= 1'b0;
    end else begin
      if (lap_req && (!lap_valid || lap_ack)) begin
        lap_time  <= count;
        lap_valid <= 1'b1;
      end else if (lap_ack) begin
        lap_valid <= 1'b0;
      end
      if (clear) begin
        lap_overrun <= 1'b0;
      end else if (lap_req && lap_valid && !lap_ack) begin
        lap_overrun <= 1'b1;
      end
    end
  end

endmodule
